// File: rtl/counter_pkg.sv
// Shared encodings for the counter limit behaviour.
// No logic, no latency, no flow control.
// Imported by the step logic and the top level.
package counter_pkg;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

endpackage

// File: rtl/updown_step.sv
// Next-count, carry and borrow for one enabled step of the up/down counter.
// Purely combinational, zero latency.
// No handshake: the result is consumed by the caller's register.
module updown_step
    import counter_pkg::*;
#(
    parameter int WIDTH    = 10,
    parameter int SAT_MODE = MODE_WRAP
) (
    input  logic [WIDTH-1:0] cur,
    input  logic             up,
    input  logic [WIDTH-1:0] max_val,
    output logic [WIDTH-1:0] nxt,
    output logic             cout,
    output logic             bout
);

    localparam bit SAT = (SAT_MODE == MODE_SAT);

    always_comb begin
        nxt  = cur;
        cout = 1'b0;
        bout = 1'b0;
        if (up) begin
            if (cur >= max_val) begin
                cout = 1'b1;
                nxt  = SAT ? max_val : '0;
            end else begin
                nxt = cur + WIDTH'(1);
            end
        end else begin
            if (cur == '0) begin
                bout = 1'b1;
                nxt  = SAT ? '0 : max_val;
            end else if (cur > max_val) begin
                // Limit lowered below the count: clamp quietly rather than borrow.
                nxt = max_val;
            end else begin
                nxt = cur - WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/loadable_updown_counter.sv
// Loadable up/down counter with run-time upper limit, wrap/saturate and sticky flags.
// Out, Cout and Bout update one cycle after the qualifying edge; AtMax/AtZero are combinational.
// No backpressure: Load and En are sampled every cycle, Load taking priority.
module loadable_updown_counter
    import counter_pkg::*;
#(
    parameter int          WIDTH    = 10,
    parameter int          SAT_MODE = MODE_WRAP,
    parameter int unsigned RST_VAL  = 0
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             En,
    input  logic             D,
    input  logic             Load,
    input  logic [WIDTH-1:0] LoadVal,
    input  logic [WIDTH-1:0] Max,
    input  logic             ClrFlags,
    output logic [WIDTH-1:0] Out,
    output logic             AtMax,
    output logic             AtZero,
    output logic             Cout,
    output logic             Bout,
    output logic             Ovf,
    output logic             Unf
);

    localparam logic [WIDTH-1:0] RST_OUT = WIDTH'(RST_VAL);

    logic [WIDTH-1:0] out_q, out_d;
    logic             cout_q, cout_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic [WIDTH-1:0] step_nxt;
    logic             step_cout;
    logic             step_bout;

    updown_step #(
        .WIDTH    (WIDTH),
        .SAT_MODE (SAT_MODE)
    ) u_step (
        .cur     (out_q),
        .up      (D),
        .max_val (Max),
        .nxt     (step_nxt),
        .cout    (step_cout),
        .bout    (step_bout)
    );

    always_comb begin
        out_d  = out_q;
        cout_d = 1'b0;
        bout_d = 1'b0;
        if (Load) begin
            out_d = (LoadVal > Max) ? Max : LoadVal;
        end else if (En) begin
            out_d  = step_nxt;
            cout_d = step_cout;
            bout_d = step_bout;
        end
        // A set event on the same edge as a clear keeps the flag high.
        ovf_d = (ovf_q & ~ClrFlags) | cout_d;
        unf_d = (unf_q & ~ClrFlags) | bout_d;
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            out_q  <= RST_OUT;
            cout_q <= 1'b0;
            bout_q <= 1'b0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else begin
            out_q  <= out_d;
            cout_q <= cout_d;
            bout_q <= bout_d;
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
        end
    end

    assign Out    = out_q;
    assign Cout   = cout_q;
    assign Bout   = bout_q;
    assign Ovf    = ovf_q;
    assign Unf    = unf_q;
    assign AtMax  = (out_q >= Max);
    assign AtZero = (out_q == '0);

endmodule

// File: tb/tb_loadable_updown_counter.sv
// Scoreboard bench: a wrap-mode and a saturate-mode counter share stimulus and are checked against a model.
module tb_loadable_updown_counter;

    localparam int W = 4;
    localparam int RST0 = 5;
    localparam int RST1 = 0;

    logic         Clk, Rst, En, D, Load, ClrFlags;
    logic [W-1:0] LoadVal, Max;

    logic [W-1:0] Out0, Out1;
    logic AtMax0, AtZero0, Cout0, Bout0, Ovf0, Unf0;
    logic AtMax1, AtZero1, Cout1, Bout1, Ovf1, Unf1;

    loadable_updown_counter #(.WIDTH(W), .SAT_MODE(0), .RST_VAL(RST0)) u_wrap (
        .Clk(Clk), .Rst(Rst), .En(En), .D(D), .Load(Load), .LoadVal(LoadVal),
        .Max(Max), .ClrFlags(ClrFlags), .Out(Out0), .AtMax(AtMax0), .AtZero(AtZero0),
        .Cout(Cout0), .Bout(Bout0), .Ovf(Ovf0), .Unf(Unf0)
    );

    loadable_updown_counter #(.WIDTH(W), .SAT_MODE(1), .RST_VAL(RST1)) u_sat (
        .Clk(Clk), .Rst(Rst), .En(En), .D(D), .Load(Load), .LoadVal(LoadVal),
        .Max(Max), .ClrFlags(ClrFlags), .Out(Out1), .AtMax(AtMax1), .AtZero(AtZero1),
        .Cout(Cout1), .Bout(Bout1), .Ovf(Ovf1), .Unf(Unf1)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        int out;
        int cout;
        int bout;
        int ovf;
        int unf;
        int atmax;
        int atzero;
    } exp_t;

    exp_t sb[$];
    int   m_out[2];
    int   m_ovf[2];
    int   m_unf[2];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string tag, input int obs, input int exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    function automatic void model_reset();
        m_out[0] = RST0;
        m_out[1] = RST1;
        for (int i = 0; i < 2; i++) begin
            m_ovf[i] = 0;
            m_unf[i] = 0;
        end
    endfunction

    // Reference behaviour: i==0 wraps at the limits, i==1 saturates.
    function automatic exp_t model_step(input int i, input int ld, input int en, input int d,
                                        input int lv, input int mx, input int clr);
        exp_t e;
        int   o;
        int   c;
        int   b;
        o = m_out[i];
        c = 0;
        b = 0;
        if (ld != 0) begin
            o = (lv < mx) ? lv : mx;
        end else if (en != 0) begin
            if (d != 0) begin
                if (o >= mx) begin
                    c = 1;
                    o = (i == 1) ? mx : 0;
                end else begin
                    o = (o + 1) % (1 << W);
                end
            end else begin
                if (o == 0) begin
                    b = 1;
                    o = (i == 1) ? 0 : mx;
                end else if (o > mx) begin
                    o = mx;
                end else begin
                    o = o - 1;
                end
            end
        end
        m_out[i] = o;
        m_ovf[i] = (c == 1) ? 1 : ((clr != 0) ? 0 : m_ovf[i]);
        m_unf[i] = (b == 1) ? 1 : ((clr != 0) ? 0 : m_unf[i]);
        e.out    = o;
        e.cout   = c;
        e.bout   = b;
        e.ovf    = m_ovf[i];
        e.unf    = m_unf[i];
        e.atmax  = (o >= mx) ? 1 : 0;
        e.atzero = (o == 0) ? 1 : 0;
        return e;
    endfunction

    task automatic compare_one(input string tag, input int idx, input int out, input int cout,
                               input int bout, input int ovf, input int unf, input int atmax,
                               input int atzero);
        exp_t e;
        string p;
        p = $sformatf("%s/%s", tag, (idx == 0) ? "wrap" : "sat");
        if (sb.size() == 0) begin
            check({p, "/sb_empty"}, 0, 1);
        end else begin
            e = sb.pop_front();
            check({p, "/Out"},    out,    e.out);
            check({p, "/Cout"},   cout,   e.cout);
            check({p, "/Bout"},   bout,   e.bout);
            check({p, "/Ovf"},    ovf,    e.ovf);
            check({p, "/Unf"},    unf,    e.unf);
            check({p, "/AtMax"},  atmax,  e.atmax);
            check({p, "/AtZero"}, atzero, e.atzero);
        end
    endtask

    task automatic step(input string tag, input logic ld, input logic en, input logic d,
                        input logic [W-1:0] lv, input logic [W-1:0] mx, input logic clr);
        Load     = ld;
        En       = en;
        D        = d;
        LoadVal  = lv;
        Max      = mx;
        ClrFlags = clr;
        for (int i = 0; i < 2; i++)
            sb.push_back(model_step(i, int'(ld), int'(en), int'(d), int'(lv), int'(mx), int'(clr)));
        @(posedge Clk);
        #1;
        compare_one(tag, 0, int'(Out0), int'(Cout0), int'(Bout0), int'(Ovf0), int'(Unf0),
                    int'(AtMax0), int'(AtZero0));
        compare_one(tag, 1, int'(Out1), int'(Cout1), int'(Bout1), int'(Ovf1), int'(Unf1),
                    int'(AtMax1), int'(AtZero1));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "/Out_wrap"}, int'(Out0), RST0);
        check({tag, "/Out_sat"},  int'(Out1), RST1);
        check({tag, "/flags_wrap"}, int'({Cout0, Bout0, Ovf0, Unf0}), 0);
        check({tag, "/flags_sat"},  int'({Cout1, Bout1, Ovf1, Unf1}), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        Rst = 1'b1; En = 1'b0; D = 1'b0; Load = 1'b0; ClrFlags = 1'b0;
        LoadVal = '0; Max = 4'd9;
        model_reset();
        #2;
        check_reset_state("reset_initial");
        #5 Rst = 1'b0;
        @(posedge Clk);
        #1;

        step("load9",      1, 0, 0, 4'd9,  4'd9, 0);
        step("up_wrap",    0, 1, 1, 4'd0,  4'd9, 0);
        step("up_after",   0, 1, 1, 4'd0,  4'd9, 0);
        step("hold",       0, 0, 1, 4'd0,  4'd9, 0);
        step("clr_alone",  0, 0, 0, 4'd0,  4'd9, 1);

        step("load0",      1, 0, 0, 4'd0,  4'd9, 0);
        for (int k = 0; k < 3; k++)
            step("down_from0", 0, 1, 0, 4'd0, 4'd9, 0);

        step("load_clamp", 1, 1, 1, 4'd12, 4'd9, 0);
        step("load7",      1, 0, 0, 4'd7,  4'd15, 0);
        step("max_lower",  0, 1, 0, 4'd0,  4'd3, 0);
        step("up_from_lim",0, 1, 1, 4'd0,  4'd3, 0);

        step("clr_prep",   1, 0, 0, 4'd3,  4'd3, 1);
        step("clr_vs_set", 0, 1, 1, 4'd0,  4'd3, 1);
        step("clr_only",   0, 0, 0, 4'd0,  4'd3, 1);

        step("load15",     1, 0, 0, 4'd15, 4'd15, 0);
        step("full_wrap",  0, 1, 1, 4'd0,  4'd15, 0);
        step("full_down",  0, 1, 0, 4'd0,  4'd15, 0);

        step("max0_up",    0, 1, 1, 4'd0,  4'd0, 0);
        step("max0_down",  0, 1, 0, 4'd0,  4'd0, 0);
        step("max0_up2",   0, 1, 1, 4'd0,  4'd0, 0);

        for (int k = 0; k < 60; k++)
            step("random", ($urandom % 6) == 0, ($urandom % 4) != 0, $urandom % 2,
                 4'($urandom), 4'($urandom), ($urandom % 8) == 0);

        // Mid-cycle reset while a carry pulse is on the outputs.
        step("pre_rst_load", 1, 0, 0, 4'd9, 4'd9, 0);
        step("pre_rst_wrap", 0, 1, 1, 4'd0, 4'd9, 0);
        #3;
        Rst = 1'b1;
        model_reset();
        #1;
        check_reset_state("reset_async");
        Load = 1'b1; LoadVal = 4'd2; En = 1'b1; D = 1'b1; ClrFlags = 1'b1;
        @(posedge Clk);
        #1;
        check_reset_state("reset_held");
        #3;
        Rst = 1'b0;
        step("after_rst_up", 0, 1, 1, 4'd0, 4'd9, 0);
        step("after_rst_up2",0, 1, 1, 4'd0, 4'd9, 0);

        check("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
